uart_bus_master: RTL and testbench

- Host-side initiator for the UART core's 3-bit register bus: chip select, read/write strobes, 8-bit data.
- Turns a single-beat valid/ready command (address, direction, write data) into a timed bus cycle: setup, strobe, hold.
- On reads, captures the register contents (mode, baud, compensation, state, RX FIFO byte) and returns them with a one-cycle response pulse.
- Sits between a CPU/test sequencer and the UART control register file.

---
 rtl/uart_bus_master.sv | 220 ++++++++++++++++++++++
 tb/tb_uart_bus_master.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : uart_bus_master
// Description : Turns valid/ready commands into timed CS/strobe register-bus
//               cycles (setup, strobe, hold) for the UART register file.
//               Optional write-verify readback: UART_BUS_WR_VERIFY_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_bus_master #(
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid_i,
    output logic       cmd_ready_o,
    input  logic       cmd_write_i,
    input  logic [2:0] cmd_addr_i,
    input  logic [7:0] cmd_wdata_i,
    output logic       rsp_valid_o,
    output logic       rsp_write_o,
    output logic [7:0] rsp_rdata_o,
    output logic       rsp_verr_o,
    output logic [2:0] AddrBus_o,
    output logic       n_ChipSelect_o,
    output logic       n_rd_o,
    output logic       n_we_o,
    output logic [7:0] DataBus_o,
    input  logic [7:0] DataBus_i
);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_SETUP  = 2'd1;
    localparam logic [1:0] c_STROBE = 2'd2;
    localparam logic [1:0] c_HOLD   = 2'd3;

    localparam logic [3:0] c_SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] c_STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] c_HOLD_LD   = 4'(HOLD_CYC - 1);

    logic [1:0] state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic       bus_wr_q, bus_wr_d;
    logic [2:0] addr_q, addr_d;
    logic [7:0] dout_q, dout_d;
    logic       cs_n_q, cs_n_d;
    logic       rd_n_q, rd_n_d;
    logic       we_n_q, we_n_d;
    logic       ready_q, ready_d;
    logic       rsp_valid_q, rsp_valid_d;
    logic       rsp_write_q, rsp_write_d;
    logic [7:0] rsp_rdata_q, rsp_rdata_d;
    logic       phase_done;
`ifdef UART_BUS_WR_VERIFY_EN
    logic [7:0] wdata_q, wdata_d;
    logic       vfy_pend_q, vfy_pend_d;
    logic       vfy_act_q, vfy_act_d;
    logic       verr_q, verr_d;
`endif

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        bus_wr_d    = bus_wr_q;
        addr_d      = addr_q;
        dout_d      = dout_q;
        rsp_valid_d = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        phase_done  = 1'b0;
`ifdef UART_BUS_WR_VERIFY_EN
        wdata_d     = wdata_q;
        vfy_pend_d  = 1'b0;
        vfy_act_d   = vfy_act_q;
        verr_d      = verr_q;
`endif
        case (state_q)
            c_IDLE: begin
`ifdef UART_BUS_WR_VERIFY_EN
                // One CS-high gap cycle, then re-read the register just written
                if (vfy_pend_q) begin
                    state_d   = c_SETUP;
                    cnt_d     = c_SETUP_LD;
                    bus_wr_d  = 1'b0;
                    dout_d    = 8'h00;
                    vfy_act_d = 1'b1;
                end else
`endif
                if (cmd_valid_i && ready_q) begin
                    state_d  = c_SETUP;
                    cnt_d    = c_SETUP_LD;
                    bus_wr_d = cmd_write_i;
                    addr_d   = cmd_addr_i;
                    dout_d   = cmd_write_i ? cmd_wdata_i : 8'h00;
`ifdef UART_BUS_WR_VERIFY_EN
                    wdata_d  = cmd_wdata_i;
`endif
                end
            end
            c_SETUP: begin
                if (cnt_q == 4'd0) begin
                    state_d = c_STROBE;
                    cnt_d   = c_STROBE_LD;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            c_STROBE: begin
                if (cnt_q == 4'd0) begin
                    if (!bus_wr_q) begin
                        rsp_rdata_d = DataBus_i;
                    end
                    if (HOLD_CYC == 0) begin
                        phase_done = 1'b1;
                    end else begin
                        state_d = c_HOLD;
                        cnt_d   = c_HOLD_LD;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                if (cnt_q == 4'd0) begin
                    phase_done = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
        endcase

        if (phase_done) begin
            state_d = c_IDLE;
`ifdef UART_BUS_WR_VERIFY_EN
            if (!vfy_act_q && bus_wr_q && (addr_q >= 3'd1) && (addr_q <= 3'd3)) begin
                vfy_pend_d = 1'b1;
            end else begin
                rsp_valid_d = 1'b1;
                rsp_write_d = bus_wr_q | vfy_act_q;
                verr_d      = vfy_act_q && (rsp_rdata_d != wdata_q);
                vfy_act_d   = 1'b0;
            end
`else
            rsp_valid_d = 1'b1;
            rsp_write_d = bus_wr_q;
`endif
        end

        cs_n_d  = (state_d == c_IDLE);
        rd_n_d  = !((state_d == c_STROBE) && !bus_wr_d);
        we_n_d  = !((state_d == c_STROBE) && bus_wr_d);
`ifdef UART_BUS_WR_VERIFY_EN
        ready_d = (state_d == c_IDLE) && !vfy_pend_d;
`else
        ready_d = (state_d == c_IDLE);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= c_IDLE;
            cnt_q       <= 4'd0;
            bus_wr_q    <= 1'b0;
            addr_q      <= 3'd0;
            dout_q      <= 8'h00;
            cs_n_q      <= 1'b1;
            rd_n_q      <= 1'b1;
            we_n_q      <= 1'b1;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= 8'h00;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bus_wr_q    <= bus_wr_d;
            addr_q      <= addr_d;
            dout_q      <= dout_d;
            cs_n_q      <= cs_n_d;
            rd_n_q      <= rd_n_d;
            we_n_q      <= we_n_d;
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

`ifdef UART_BUS_WR_VERIFY_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wdata_q    <= 8'h00;
            vfy_pend_q <= 1'b0;
            vfy_act_q  <= 1'b0;
            verr_q     <= 1'b0;
        end else begin
            wdata_q    <= wdata_d;
            vfy_pend_q <= vfy_pend_d;
            vfy_act_q  <= vfy_act_d;
            verr_q     <= verr_d;
        end
    end
    assign rsp_verr_o = verr_q;
`else
    assign rsp_verr_o = 1'b0;
`endif

    assign cmd_ready_o    = ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_write_o    = rsp_write_q;
    assign rsp_rdata_o    = rsp_rdata_q;
    assign AddrBus_o      = addr_q;
    assign n_ChipSelect_o = cs_n_q;
    assign n_rd_o         = rd_n_q;
    assign n_we_o         = we_n_q;
    assign DataBus_o      = dout_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_bus_master.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_uart_bus_master
// Description : Directed self-checking bench for uart_bus_master (default
//               timing plus a HOLD_CYC=0 instance sharing the command inputs).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_bus_master;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_write = 1'b0;
    logic [2:0] cmd_addr  = 3'd0;
    logic [7:0] cmd_wdata = 8'h00;
    logic [7:0] slave_byte = 8'h00;

    wire        ready, rv, rw, verr, cs_n, rd_n, we_n;
    wire [7:0]  rdata, dout, din;
    wire [2:0]  addr;
    wire        ready0, rv0, rw0, verr0, cs_n0, rd_n0, we_n0;
    wire [7:0]  rdata0, dout0, din0;
    wire [2:0]  addr0;

    int checks = 0;
    int errors = 0;

`ifdef UART_BUS_WR_VERIFY_EN
    localparam int DONE  = 10;
    localparam int DONE0 = 8;
    localparam bit VFY   = 1'b1;
`else
    localparam int DONE  = 5;
    localparam int DONE0 = 4;
    localparam bit VFY   = 1'b0;
`endif

    // Register-file model: drives the slave byte only while its read strobe is low
    assign din  = (rd_n  == 1'b0) ? slave_byte : 8'h00;
    assign din0 = (rd_n0 == 1'b0) ? slave_byte : 8'h00;

    always #5 clk = ~clk;

    uart_bus_master dut (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(ready), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rv), .rsp_write_o(rw), .rsp_rdata_o(rdata), .rsp_verr_o(verr),
        .AddrBus_o(addr), .n_ChipSelect_o(cs_n), .n_rd_o(rd_n), .n_we_o(we_n),
        .DataBus_o(dout), .DataBus_i(din)
    );

    uart_bus_master #(.SETUP_CYC(1), .STROBE_CYC(2), .HOLD_CYC(0)) dut0 (
        .clk(clk), .rst(rst),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(ready0), .cmd_write_i(cmd_write),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rv0), .rsp_write_o(rw0), .rsp_rdata_o(rdata0), .rsp_verr_o(verr0),
        .AddrBus_o(addr0), .n_ChipSelect_o(cs_n0), .n_rd_o(rd_n0), .n_we_o(we_n0),
        .DataBus_o(dout0), .DataBus_i(din0)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [25:0] idle_vec;
        idle_vec = {1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b1, 1'b1, 8'h00};
        rst = 1'b0;
        repeat (3) step();
        checks++;
        if ({ready, rv, rw, rdata, verr, addr, cs_n, rd_n, we_n, dout} !== idle_vec) begin
            errors++;
            $display("FAIL reset_values got %h exp %h",
                     {ready, rv, rw, rdata, verr, addr, cs_n, rd_n, we_n, dout}, idle_vec);
        end
        rst = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            checks++;
            if ({ready, rv, rw, rdata, verr, addr, cs_n, rd_n, we_n, dout} !== idle_vec) begin
                errors++;
                $display("FAIL idle_ready cyc=%0d got %h exp %h", k,
                         {ready, rv, rw, rdata, verr, addr, cs_n, rd_n, we_n, dout}, idle_vec);
            end
        end
    endtask

    task automatic test_write;
        logic exp_cs_n, exp_we_n, exp_rv;
        slave_byte = 8'h14;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 3'd2; cmd_wdata = 8'h14;
        checks++;
        if (ready !== 1'b1) begin
            errors++;
            $display("FAIL write_ready_at_T got %b exp 1", ready);
        end
        for (int k = 1; k <= 11; k++) begin
            step();
            if (k == 1) cmd_valid = 1'b0;
            exp_cs_n = !((k >= 1 && k <= 4) || (VFY && k >= 6 && k <= 9));
            exp_we_n = !(k == 2 || k == 3);
            exp_rv   = (k == DONE);
            checks++;
            if ({cs_n, we_n, rv} !== {exp_cs_n, exp_we_n, exp_rv}) begin
                errors++;
                $display("FAIL write_timing cyc=%0d got cs/we/rv=%b%b%b exp %b%b%b",
                         k, cs_n, we_n, rv, exp_cs_n, exp_we_n, exp_rv);
            end
            checks++;
            if (rv0 !== (k == DONE0)) begin
                errors++;
                $display("FAIL write_hold0_rv cyc=%0d got %b exp %b", k, rv0, (k == DONE0));
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if ({addr, dout, ready} !== {3'd2, 8'h14, 1'b0}) begin
                    errors++;
                    $display("FAIL write_bus cyc=%0d got addr=%0d data=%h rdy=%b exp 2 14 0",
                             k, addr, dout, ready);
                end
            end
            if (k == DONE) begin
                checks++;
                if ({rw, verr, ready} !== 3'b101) begin
                    errors++;
                    $display("FAIL write_rsp got rw/verr/rdy=%b%b%b exp 101", rw, verr, ready);
                end
            end
        end
    endtask

    task automatic test_read;
        logic exp_rd_n, exp_rv;
        slave_byte = 8'hA5;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd7; cmd_wdata = 8'hFF;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (k == 1) cmd_valid = 1'b0;
            exp_rd_n = !(k == 2 || k == 3);
            exp_rv   = (k == 5);
            checks++;
            if ({cs_n, rd_n, we_n, rv} !== {(k == 5 || k == 6), exp_rd_n, 1'b1, exp_rv}) begin
                errors++;
                $display("FAIL read_timing cyc=%0d got cs/rd/we/rv=%b%b%b%b", k, cs_n, rd_n, we_n, rv);
            end
            if (k >= 1 && k <= 4) begin
                checks++;
                if ({addr, dout} !== {3'd7, 8'h00}) begin
                    errors++;
                    $display("FAIL read_bus cyc=%0d got addr=%0d data=%h exp 7 00", k, addr, dout);
                end
            end
            if (k >= 5) begin
                checks++;
                if ({rdata, rw} !== {8'hA5, 1'b0}) begin
                    errors++;
                    $display("FAIL read_rsp cyc=%0d got rdata=%h rw=%b exp a5 0", k, rdata, rw);
                end
            end
        end
    endtask

    task automatic test_back_to_back;
        logic b;
        for (int k = 0; k <= 15; k++) begin
            if (k > 0) step();
            cmd_valid  = (k <= 10);
            cmd_write  = 1'b0;
            cmd_addr   = 3'(3 + k / 5);
            slave_byte = 8'(8'h30 + k / 5);
            b = (k % 5 == 0);
            checks++;
            if ({ready, cs_n, rv} !== {b, b, b && (k > 0)}) begin
                errors++;
                $display("FAIL b2b_timing cyc=%0d got rdy/cs/rv=%b%b%b exp %b%b%b",
                         k, ready, cs_n, rv, b, b, b && (k > 0));
            end
            if (!b) begin
                checks++;
                if (addr !== 3'(3 + k / 5)) begin
                    errors++;
                    $display("FAIL b2b_addr cyc=%0d got %0d exp %0d", k, addr, 3 + k / 5);
                end
            end
            if (b && k > 0) begin
                checks++;
                if (rdata !== 8'(8'h30 + k / 5 - 1)) begin
                    errors++;
                    $display("FAIL b2b_rdata cyc=%0d got %h exp %h", k, rdata, 8'h30 + k / 5 - 1);
                end
            end
        end
        cmd_valid = 1'b0;
    endtask

    task automatic test_reset_mid;
        slave_byte = 8'h5A;
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 3'd1;
        step();
        cmd_valid = 1'b0;
        step();
        checks++;
        if ({cs_n, rd_n} !== 2'b00) begin
            errors++;
            $display("FAIL rstmid_in_strobe got cs/rd=%b%b exp 00", cs_n, rd_n);
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({cs_n, rd_n, we_n, ready, rv} !== 5'b11110) begin
            errors++;
            $display("FAIL rstmid_idle got cs/rd/we/rdy/rv=%b%b%b%b%b exp 11110",
                     cs_n, rd_n, we_n, ready, rv);
        end
        step();
        step();
        rst = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            checks++;
            if ({rv, cs_n, rd_n} !== 3'b011) begin
                errors++;
                $display("FAIL rstmid_no_rsp cyc=%0d got rv/cs/rd=%b%b%b exp 011", k, rv, cs_n, rd_n);
            end
        end
        test_write();
    endtask

`ifdef UART_BUS_WR_VERIFY_EN
    task automatic test_verify(input logic [2:0] a, input logic [7:0] wd,
                               input logic [7:0] sb, input logic exp_verr, input int done_k);
        slave_byte = sb;
        cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = a; cmd_wdata = wd;
        for (int k = 1; k <= done_k + 1; k++) begin
            step();
            if (k == 1) cmd_valid = 1'b0;
            checks++;
            if (rv !== (k == done_k)) begin
                errors++;
                $display("FAIL verify_rv a=%0d cyc=%0d got %b exp %b", a, k, rv, (k == done_k));
            end
            if (done_k == 10 && k == 5) begin
                checks++;
                if ({cs_n, ready} !== 2'b10) begin
                    errors++;
                    $display("FAIL verify_gap got cs/rdy=%b%b exp 10", cs_n, ready);
                end
            end
            if (done_k == 10 && (k == 7 || k == 8)) begin
                checks++;
                if ({rd_n, we_n, dout} !== {1'b0, 1'b1, 8'h00}) begin
                    errors++;
                    $display("FAIL verify_read cyc=%0d got rd/we/data=%b%b%h", k, rd_n, we_n, dout);
                end
            end
            if (k == done_k) begin
                checks++;
                if ({rw, verr} !== {1'b1, exp_verr}) begin
                    errors++;
                    $display("FAIL verify_rsp a=%0d got rw/verr=%b%b exp 1%b", a, rw, verr, exp_verr);
                end
                if (done_k == 10) begin
                    checks++;
                    if (rdata !== sb) begin
                        errors++;
                        $display("FAIL verify_rdata got %h exp %h", rdata, sb);
                    end
                end
            end
        end
    endtask
`endif

    initial begin
        fork
            begin
                #200000;
                $display("FAIL timeout CHECKS %0d ERRORS %0d", checks, errors);
                $fatal(1);
            end
        join_none
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid();
`ifdef UART_BUS_WR_VERIFY_EN
        test_verify(3'd1, 8'h61, 8'h60, 1'b1, 10);
        test_verify(3'd1, 8'h61, 8'h61, 1'b0, 10);
        test_verify(3'd7, 8'h61, 8'h00, 1'b0, 5);
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
